img_frame_gate_ctrl: RTL
========================

Name: img_frame_gate_ctrl

Overview:
- Frame-level scheduler between the camera capture output and the image packetizer, entirely in the cam_pclk domain.
- Decides which camera frames reach the packetizer: starts and stops transfer only on frame boundaries and decimates frames by a programmable ratio.
- Checks the geometry of each forwarded frame and counts forwarded frames for status readback.
- Frames that are not forwarded are hidden from the packetizer: its vsync is held high and its data enable is held low.

Parameters:
CMOS_H_PIXEL, 16'd640, horizontal resolution in pixels
CMOS_V_PIXEL, 16'd480, vertical resolution in lines
BYTES_PER_PIX, 2, bytes per pixel; expected bytes per line H_BYTES = CMOS_H_PIXEL*BYTES_PER_PIX (16 bit)

Ports:
cam_pclk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
transfer_flag  in  1  transfer enable from the Ethernet domain; asynchronous, synchronised internally by 2 flops (tf_sync)
frame_skip  in  4  decimation: forward 1 frame, then skip frame_skip frames
cam_vsync  in  1  camera vsync; high = vertical blanking, low = active frame
cam_data_en  in  1  camera byte valid
cam_data  in  8  camera byte
img_vsync  out  1  gated vsync to packetizer
img_data_en  out  1  gated byte valid to packetizer
img_data  out  8  byte to packetizer
frame_active  out  1  high while state == PASS
frame_cnt  out  16  number of completed forwarded frames; wraps 0xFFFF -> 0
err_geom  out  1  1-cycle pulse at end of a forwarded frame with bad geometry
err_sticky  out  1  set by err_geom; cleared only by reset or by a rising edge of tf_sync

Behaviour:
- Input stage: cam_vsync, cam_data_en and cam_data are registered into the d0 stage, then cam_vsync additionally into the d1 stage.
- Frame edges: SOF = d1 & ~d0 (vsync falling edge); EOF = ~d1 & d0 (vsync rising edge).
- States:
  - IDLE: reset state.
  - WAIT_SOF
  - PASS
  - SKIP
- Transitions:
  - IDLE -> WAIT_SOF when tf_sync=1 and vsync_d0=1 (blanking). If enabled mid-frame, the block waits for blanking and never starts a partial frame.
  - WAIT_SOF -> IDLE if tf_sync=0.
  - WAIT_SOF, on SOF with skip_cnt==0 -> PASS; skip_cnt <= frame_skip.
  - WAIT_SOF, on SOF with skip_cnt!=0 -> SKIP; skip_cnt <= skip_cnt-1.
  - PASS or SKIP, on EOF -> WAIT_SOF if tf_sync=1, else IDLE.
  - Deasserting tf_sync mid-frame never truncates the frame: the current frame completes.
- skip_cnt: 4 bit, reset 0, forced to 0 in IDLE. frame_skip is sampled only at SOF, so the first frame after enable is always forwarded.
- Output registers (latency 2 cam_pclk from input pins):
  - img_vsync <= vsync_d0 when next state is PASS, or when the current state is PASS (so the EOF rising edge propagates); otherwise 1.
  - img_data_en <= data_en_d0 & (current state == PASS).
  - img_data <= data_d0 when data_en_d0 & PASS, else 8'd0.
- Geometry check, active only in PASS:
  - byte_cnt (16 bit) counts data_en_d0 cycles.
  - On each data_en_d0 falling edge: line_cnt+1; if byte_cnt != H_BYTES then set bad_line; byte_cnt <= 0.
  - On EOF: error if bad_line, or line_cnt != CMOS_V_PIXEL, or a line still open (data_en_d0=1 at EOF).
  - Error response: err_geom pulses in the cycle after EOF and err_sticky is set.
  - All counters clear at SOF.
  - byte_cnt and line_cnt saturate at 0xFFFF.
- frame_cnt: increments by 1 at the EOF of every PASS frame, regardless of errors. SKIP frames are not counted.
- Reset values: img_vsync=1, img_data_en=0, img_data=0, frame_active=0, frame_cnt=0, err_geom=0, err_sticky=0, state IDLE, all counters 0.
- Reset mid-frame: outputs return to their reset values immediately (async). After release the block restarts in IDLE and waits for blanking.
- SOF and EOF in the same cycle are impossible (single vsync bit). A glitch frame of 0 lines in PASS gives line_cnt=0 -> err_geom.

Test Plan:
- Basic forwarding: tf=1, skip=0, three 640x480 frames (1280 bytes/line) -> all three forwarded bit-exact; img_vsync falls 2 cycles after cam_vsync; frame_cnt=3; err_geom never asserts.
- Decimation: skip=2, seven frames -> frames 1, 4, 7 forwarded; img_vsync stays high during frames 2, 3, 5, 6; frame_cnt=3.
- Enable mid-frame: tf rises at line 100 of frame 1 -> frame 1 fully suppressed, frame 2 forwarded complete; first img_data_en is byte 0 of line 0.
- Disable mid-frame: tf falls at line 200 of a PASS frame -> all 480 lines still forwarded; next frame suppressed; state returns to IDLE; frame_cnt +1.
- Geometry error: line 37 with 1278 bytes -> err_geom single pulse one cycle after EOF, err_sticky=1, frame_cnt still increments. Then a frame with 479 lines -> err_geom again. A tf rising edge clears err_sticky.
- Reset mid-frame: rst_n low for 3 cycles at line 250 -> outputs at reset values; the remainder of that frame is suppressed; the next full frame is forwarded with frame_cnt=1.

Source files
------------

// File: rtl/img_frame_gate_ctrl.sv
// Frame-level gate between camera capture and packetizer: starts/stops on frame boundaries,
// decimates frames, checks forwarded-frame geometry and counts forwarded frames.
module img_frame_gate_ctrl #(
  parameter logic [15:0] CMOS_H_PIXEL  = 16'd640,
  parameter logic [15:0] CMOS_V_PIXEL  = 16'd480,
  parameter int unsigned BYTES_PER_PIX = 2
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        transfer_flag,
  input  logic [3:0]  frame_skip,
  input  logic        cam_vsync,
  input  logic        cam_data_en,
  input  logic [7:0]  cam_data,
  output logic        img_vsync,
  output logic        img_data_en,
  output logic [7:0]  img_data,
  output logic        frame_active,
  output logic [15:0] frame_cnt,
  output logic        err_geom,
  output logic        err_sticky
);

  localparam logic [15:0] H_BYTES = 16'(CMOS_H_PIXEL * BYTES_PER_PIX);

  typedef enum logic [1:0] {StIdle, StWaitSof, StPass, StSkip} state_t;

  state_t      r_state, w_state_next;
  logic        r_tf_meta, r_tf_sync, r_tf_sync_d;
  logic        r_vsync_d0, r_vsync_d1, r_de_d0, r_de_d1;
  logic [7:0]  r_data_d0;
  logic [3:0]  r_skip_cnt, w_skip_next;
  logic [15:0] r_byte_cnt, r_line_cnt, w_line_inc, w_lines_eff;
  logic        r_bad_line;
  logic        r_img_vsync, r_img_de, r_err_geom, r_err_sticky;
  logic [7:0]  r_img_data;
  logic [15:0] r_frame_cnt;
  logic        w_sof, w_eof, w_pass, w_de_fall, w_tf_rise, w_line_end, w_frame_end, w_geom_bad;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tf_meta   <= 1'b0;
      r_tf_sync   <= 1'b0;
      r_tf_sync_d <= 1'b0;
      r_vsync_d0  <= 1'b1;
      r_vsync_d1  <= 1'b1;
      r_de_d0     <= 1'b0;
      r_de_d1     <= 1'b0;
      r_data_d0   <= 8'd0;
    end else begin
      r_tf_meta   <= transfer_flag;
      r_tf_sync   <= r_tf_meta;
      r_tf_sync_d <= r_tf_sync;
      r_vsync_d0  <= cam_vsync;
      r_vsync_d1  <= r_vsync_d0;
      r_de_d0     <= cam_data_en;
      r_de_d1     <= r_de_d0;
      r_data_d0   <= cam_data;
    end
  end

  assign w_sof       = r_vsync_d1 & ~r_vsync_d0;
  assign w_eof       = ~r_vsync_d1 & r_vsync_d0;
  assign w_pass      = (r_state == StPass);
  assign w_de_fall   = r_de_d1 & ~r_de_d0;
  assign w_tf_rise   = r_tf_sync & ~r_tf_sync_d;
  assign w_line_end  = w_pass & w_de_fall;
  assign w_frame_end = w_pass & w_eof;
  assign w_line_inc  = (r_line_cnt == 16'hFFFF) ? r_line_cnt : r_line_cnt + 16'd1;
  // A line that closes in the EOF cycle itself still belongs to the frame.
  assign w_lines_eff = w_line_end ? w_line_inc : r_line_cnt;
  assign w_geom_bad  = r_bad_line | (w_line_end & (r_byte_cnt != H_BYTES)) |
                       (w_lines_eff != CMOS_V_PIXEL) | r_de_d0;

  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip_cnt;
    unique case (r_state)
      StIdle: begin
        w_skip_next = 4'd0;
        if (r_tf_sync && r_vsync_d0) w_state_next = StWaitSof;
      end
      StWaitSof: begin
        if (!r_tf_sync) begin
          w_state_next = StIdle;
        end else if (w_sof) begin
          if (r_skip_cnt == 4'd0) begin
            w_state_next = StPass;
            w_skip_next  = frame_skip;
          end else begin
            w_state_next = StSkip;
            w_skip_next  = r_skip_cnt - 4'd1;
          end
        end
      end
      StPass, StSkip: begin
        if (w_eof) w_state_next = r_tf_sync ? StWaitSof : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_skip_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_skip_cnt <= w_skip_next;
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 16'd0;
      r_line_cnt <= 16'd0;
      r_bad_line <= 1'b0;
    end else if (w_sof) begin
      r_byte_cnt <= 16'd0;
      r_line_cnt <= 16'd0;
      r_bad_line <= 1'b0;
    end else if (w_pass) begin
      if (r_de_d0) begin
        if (r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
      end else if (w_de_fall) begin
        r_byte_cnt <= 16'd0;
        r_line_cnt <= w_line_inc;
        if (r_byte_cnt != H_BYTES) r_bad_line <= 1'b1;
      end
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_img_vsync  <= 1'b1;
      r_img_de     <= 1'b0;
      r_img_data   <= 8'd0;
      r_frame_cnt  <= 16'd0;
      r_err_geom   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_img_vsync <= ((w_state_next == StPass) || w_pass) ? r_vsync_d0 : 1'b1;
      r_img_de    <= r_de_d0 & w_pass;
      r_img_data  <= (r_de_d0 && w_pass) ? r_data_d0 : 8'd0;
      r_err_geom  <= w_frame_end & w_geom_bad;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_frame_end && w_geom_bad) r_err_sticky <= 1'b1;
      else if (w_tf_rise)            r_err_sticky <= 1'b0;
    end
  end

  assign img_vsync    = r_img_vsync;
  assign img_data_en  = r_img_de;
  assign img_data     = r_img_data;
  assign frame_active = w_pass;
  assign frame_cnt    = r_frame_cnt;
  assign err_geom     = r_err_geom;
  assign err_sticky   = r_err_sticky;

endmodule
